// File: rtl/wave_buf_pkg.sv
// Shared types and default geometry for the arbitrary-wave sample buffer.
package wave_buf_pkg;
  localparam int DATA_W_DEF = 9;
  localparam int ADDR_W_DEF = 11;

  typedef enum logic [1:0] {
    EMPTY,
    RECORD,
    PLAY,
    DONE
  } wave_state_t;
endpackage

// File: rtl/wave_buf_ram.sv
// Single-port synchronous sample RAM with registered read; writes take the port over reads.
module wave_buf_ram
  import wave_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/wave_sample_buffer.sv
// Record-then-play sample store. Define WAVE_BUF_ONESHOT_EN to honour `loop`;
// otherwise playback always loops and DONE is unreachable.
module wave_sample_buffer
  import wave_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              adv,
  input  logic              loop,
  input  logic              restart,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [ADDR_W:0]   len,
  output logic              of,
  output logic              done
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  wave_state_t       state, state_nxt;
  logic [ADDR_W-1:0] rp;
  logic              loop_eff, full, rp_last, play_act, restart_act, rd_go;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] rd_data_p0;
  logic              vld_p0, last_p0;

`ifdef WAVE_BUF_ONESHOT_EN
  assign loop_eff = loop;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign loop_eff    = 1'b1;
`endif

  assign full    = (len == DEPTH);
  assign rp_last = ({1'b0, rp} == (len - (ADDR_W+1)'(1)));
  // The cycle right after the last write already counts as playback.
  assign play_act    = (state == PLAY) || (state == RECORD && !wr && len != '0);
  assign restart_act = restart && !wr && (state == PLAY || state == DONE);
  assign rd_go       = play_act && adv && !wr && !restart_act;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (wr)                                  state_nxt = RECORD;
    else if (restart_act)                    state_nxt = PLAY;
    else if (rd_go && rp_last && !loop_eff)  state_nxt = DONE;
    else if (state == RECORD && len != '0)   state_nxt = PLAY;
  end

  always_comb begin
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = rp;
    if (!rst) begin
      if (wr && !(state == RECORD && full)) begin
        ram_we   = 1'b1;
        ram_addr = (state == RECORD) ? len[ADDR_W-1:0] : '0;
      end else if (rd_go) begin
        ram_re = 1'b1;
      end
    end
  end

  wave_buf_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (data_in),
    .rdata (rd_data_p0)
  );

  // Stage p0: RAM read issued; stage p1: sample presented on the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      len        <= '0;
      rp         <= '0;
      of         <= 1'b0;
      vld_p0     <= 1'b0;
      last_p0    <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
      done       <= 1'b0;
    end else begin
      vld_p0  <= ram_re;
      last_p0 <= ram_re && rp_last && !loop_eff;

      if (wr) begin
        rp <= '0;
        if (state != RECORD) begin
          len <= (ADDR_W+1)'(1);
          of  <= 1'b0;
        end else if (full) begin
          of  <= 1'b1;
        end else begin
          len <= len + (ADDR_W+1)'(1);
        end
      end else if (restart_act) begin
        rp <= '0;
      end else if (rd_go) begin
        rp <= rp_last ? '0 : rp + ADDR_W'(1);
      end

      data_valid <= vld_p0 && !wr;
      if (vld_p0 && !wr) data_out <= rd_data_p0;

      if (wr || restart_act)      done <= 1'b0;
      else if (vld_p0 && last_p0) done <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wave_sample_buffer.sv
// Scoreboard bench for wave_sample_buffer (depth 8); one-shot checks follow WAVE_BUF_ONESHOT_EN.
module tb_wave_sample_buffer;
  localparam int DW = 9;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst, wr, adv, loop, restart;
  logic [DW-1:0] data_in, data_out;
  logic          data_valid, of, done;
  logic [AW:0]   len;

  always #5 clk = ~clk;

  wave_sample_buffer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr),
    .data_in    (data_in),
    .adv        (adv),
    .loop       (loop),
    .restart    (restart),
    .data_out   (data_out),
    .data_valid (data_valid),
    .len        (len),
    .of         (of),
    .done       (done)
  );

  int            n_chk = 0;
  int            n_err = 0;
  int            vld_cnt = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] mmem [8];
  int            mlen = 0;
  int            mrp = 0;
  bit            mdone = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && data_valid) begin
      vld_cnt++;
      if (exp_q.size() == 0) check("unexpected_valid", 32'(data_valid), 32'd0);
      else                   check("sample", 32'(data_out), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic record(input int n, input logic [DW-1:0] base);
    mlen  = 0;
    mrp   = 0;
    mdone = 1'b0;
    for (int i = 0; i < n; i++) begin
      wr      = 1'b1;
      data_in = base + DW'(i);
      if (mlen < 8) begin
        mmem[mlen] = data_in;
        mlen++;
      end
      tick();
    end
    wr = 1'b0;
  endtask

  task automatic play(input int n, input bit toggle);
    bit lp;
    for (int i = 0; i < n; i++) begin
`ifdef WAVE_BUF_ONESHOT_EN
      lp = loop;
`else
      lp = 1'b1;
`endif
      adv = !(toggle && i[0]);
      if (adv && !mdone) begin
        exp_q.push_back(mmem[mrp]);
        if (mrp == mlen - 1) begin
          mrp = 0;
          if (!lp) mdone = 1'b1;
        end else begin
          mrp++;
        end
      end
      tick();
    end
    adv = 1'b0;
  endtask

  task automatic drain();
    adv = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    rst = 1'b1; wr = 1'b0; adv = 1'b0; loop = 1'b1; restart = 1'b0; data_in = '0;
    repeat (2) tick();
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_len", 32'(len), 32'd0);
    check("rst_of", 32'(of), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    // Loop playback with first-sample latency.
    record(3, 9'h010);
    check("loop_len", 32'(len), 32'd3);
    v0 = vld_cnt;
    play(1, 1'b0);
    check("lat_edge1_valid", 32'(data_valid), 32'd0);
    play(1, 1'b0);
    check("lat_edge2_valid", 32'(data_valid), 32'd1);
    play(8, 1'b0);
    drain();
    check("loop_count", 32'(vld_cnt - v0), 32'd10);

    // Rate gating.
    v0 = vld_cnt;
    play(8, 1'b1);
    drain();
    check("gate_count", 32'(vld_cnt - v0), 32'd4);

    // One-shot and restart.
    loop = 1'b0;
    record(3, 9'h010);
    play(6, 1'b0);
    drain();
`ifdef WAVE_BUF_ONESHOT_EN
    check("oneshot_done", 32'(done), 32'd1);
    check("oneshot_valid", 32'(data_valid), 32'd0);
    check("oneshot_hold", 32'(data_out), 32'h012);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    mrp = 0;
    mdone = 1'b0;
    check("restart_done", 32'(done), 32'd0);
    play(4, 1'b0);
    drain();
    check("replay_done", 32'(done), 32'd1);
`else
    check("legacy_done", 32'(done), 32'd0);
`endif
    loop = 1'b1;

    // Overflow.
    record(10, 9'h000);
    check("ovf_len", 32'(len), 32'd8);
    check("ovf_of", 32'(of), 32'd1);
    play(8, 1'b0);
    drain();

    // Re-record mid-playback (wr wins over a simultaneous adv).
    play(3, 1'b0);
    tick();
    adv = 1'b1;
    record(1, 9'h1FF);
    check("rerec_len", 32'(len), 32'd1);
    check("rerec_of", 32'(of), 32'd0);
    play(4, 1'b0);
    drain();

    // Reset mid-PLAY.
    play(3, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
    adv = 1'b1;
    tick();
    check("midrst_data_out", 32'(data_out), 32'd0);
    check("midrst_valid", 32'(data_valid), 32'd0);
    check("midrst_len", 32'(len), 32'd0);
    check("midrst_of", 32'(of), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (4) tick();
    check("postrst_valid", 32'(data_valid), 32'd0);
    check("postrst_len", 32'(len), 32'd0);
    adv = 1'b0;
    repeat (2) tick();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/wave_sample_buffer.md
# wave_sample_buffer

Parametrised sample store for the arbitrary wave generator. It records a burst of samples written on consecutive `wr` cycles, then plays the stored sequence back from address 0. Playback is rate-gated by an advance strobe and runs either looped or one-shot. It sits between the host-side sample loader and the DAC output stage, and supersedes the fixed 9-bit/2048-deep auto-address RAM.

## Interface
- `DATA_W`, 9, sample width in bits
- `ADDR_W`, 11, address width; depth = 2^ADDR_W samples
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `wr`  in  1  write strobe; each high cycle stores one `data_in`
- `data_in`  in  DATA_W  sample to store
- `adv`  in  1  playback advance; one sample read per high cycle in PLAY
- `loop`  in  1  1 = wrap to address 0 after last sample; 0 = stop (one-shot)
- `restart`  in  1  rewind playback to address 0 and enter PLAY
- `data_out`  out  DATA_W  registered playback sample
- `data_valid`  out  1  pulses high for the cycle `data_out` carries a newly read sample
- `len`  out  ADDR_W+1  number of stored samples, 0..2^ADDR_W
- `of`  out  1  sticky overflow: a write arrived while `len` = 2^ADDR_W
- `done`  out  1  one-shot playback finished

## Operation
- The block has four states: EMPTY, RECORD, PLAY and DONE.
- Reset behaviour:
  - The block enters EMPTY.
  - `data_out`=0, `data_valid`=0, `len`=0, `of`=0, `done`=0.
  - RAM contents are not cleared.
- A `wr` arriving in EMPTY, PLAY or DONE:
  - clears `len`, `of` and `done`;
  - stores the sample at address 0;
  - moves the block to RECORD.
- RECORD:
  - Each `wr` cycle stores at address `len` and increments `len`.
  - At `len` = 2^ADDR_W, further writes are dropped and set `of`.
  - When `wr` is low, the block goes to PLAY if `len`>0.
- PLAY:
  - Read pointer `rp` starts at 0.
  - On an `adv` cycle, the block reads `rp` and advances it.
  - When `rp` = `len`-1 is read:
    - with `loop`=1, `rp` wraps to 0;
    - with `loop`=0, the next state is DONE.
- DONE:
  - `done`=1 and `data_out` holds the last sample.
  - `adv` is ignored.
- `restart` in PLAY or DONE sets `rp`=0, clears `done` and enters PLAY. It is ignored in EMPTY and RECORD.
- Priority when events coincide: `rst` > `wr` > `restart` > `adv`. A `wr` during PLAY aborts playback immediately.
- `len` is ADDR_W+1 bits wide so the full-depth count is representable. `rp` is ADDR_W bits wide.

## Timing
- Write latency:
  - A `wr` in cycle N writes the RAM at edge N.
  - `len` shows the new count after edge N.
- The first PLAY cycle is the cycle after the last `wr`.
- Read latency:
  - `adv` in cycle N issues the RAM read.
  - `data_out` and `data_valid` update after edge N+1, i.e. a one-cycle read latency.
- With `adv` held high, one new sample appears per cycle with no bubble at the loop wrap.
- `done` rises on the same edge that presents the last sample, together with `data_valid`.
- `data_valid` is low in EMPTY, RECORD and DONE, except for the last-sample pulse described above.
- Reset mid-operation takes effect on the next edge. No read or write is issued in that cycle.

## Configuration
- `WAVE_BUF_ONESHOT_EN`:
  - Defined: the `loop` port selects looped or one-shot playback, as described above.
  - Undefined: `loop` is ignored and treated as 1. Playback always loops, `done` is tied to 0 and DONE is unreachable (legacy continuous behaviour).

## Structure
- Package `wave_buf_pkg`:
  - state enum (EMPTY, RECORD, PLAY, DONE);
  - default DATA_W/ADDR_W constants.
- Sub-module `wave_buf_ram`:
  - single-port synchronous RAM, DATA_W × 2^ADDR_W, inferable as BSRAM;
  - ports: write enable, address and a registered read;
  - RECORD and PLAY are exclusive, so one port suffices.
- The top level holds the FSM, `len`, `rp`, `of` and the output registers.

## Test plan
- **Loop playback**
  - Stimulus: reset, then `wr` high 3 cycles with 0x010, 0x011, 0x012; then `adv`=1, `loop`=1.
  - Response: `len`=3; `data_out` = 0x010, 0x011, 0x012, 0x010, … with `data_valid` high every cycle, the first sample 2 cycles after `wr` falls.
- **One-shot and restart** (macro defined)
  - Stimulus: same data with `loop`=0; then pulse `restart`.
  - Response: 0x010, 0x011, 0x012, then `done`=1, `data_valid`=0 and `data_out` held at 0x012. After `restart`, the sequence replays from 0x010.
- **Overflow** (ADDR_W=3)
  - Stimulus: `wr` for 10 cycles with values 0..9.
  - Response: `len`=8, `of`=1; playback yields 0..7.
- **Rate gating**
  - Stimulus: `adv` toggles every cycle.
  - Response: one `data_valid` pulse per two cycles; the sample order is unchanged.
- **Re-record mid-playback**
  - Stimulus: `wr` during PLAY with 0x1FF.
  - Response: playback aborts, `len`=1, `of`=0; playback then repeats 0x1FF.
- **Reset mid-PLAY**
  - Stimulus: `rst` asserted during PLAY.
  - Response: all outputs 0 after the next edge; `adv` has no effect until a new `wr`.
